// File: rtl/dpram_arb_pkg.sv
// Shared widths and port-select type for the dual-port RAM arbiter.
package dpram_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_REQ    = 4;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_sel_e;

endpackage

// File: rtl/dpram_arb_rr_pick.sv
// Circular first-one search over a request mask, starting at i_start.
module dpram_arb_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_mask,
  input  logic [IW-1:0] i_start,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);

  // Walk offsets high to low so the nearest set bit wins.
  always_comb begin
    o_found = |i_mask;
    o_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_mask[(int'(i_start) + k) % N]) begin
        o_idx = IW'((int'(i_start) + k) % N);
      end
    end
  end

endmodule

// File: rtl/dpram_arbiter.sv
// Round-robin arbiter mapping NUM_REQ requesters onto the two ports
// of a registered, read-first dual-port RAM.
module dpram_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [NUM_REQ*DATA_WIDTH-1:0]  rsp_rdata,
  output logic                           we_a,
  output logic [ADDR_WIDTH-1:0]          addr_a,
  output logic [DATA_WIDTH-1:0]          din_a,
  output logic                           we_b,
  output logic [ADDR_WIDTH-1:0]          addr_b,
  output logic [DATA_WIDTH-1:0]          din_b,
  input  logic [DATA_WIDTH-1:0]          dout_a,
  input  logic [DATA_WIDTH-1:0]          dout_b
);

  localparam int IW = $clog2(NUM_REQ);

  logic [ADDR_WIDTH-1:0] w_addr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_wdata [NUM_REQ];

  logic [IW-1:0]      r_ptr;
  logic [NUM_REQ-1:0] r_rsp_valid;
  port_sel_e          r_tag [NUM_REQ];

  logic               w_a_found;
  logic [IW-1:0]      w_a_idx;
  logic               w_b_found;
  logic [IW-1:0]      w_b_idx;
  logic [IW-1:0]      w_b_start;
  logic [NUM_REQ-1:0] w_b_mask;
  logic               w_a_gnt;
  logic               w_b_gnt;

  function automatic logic [IW-1:0] f_next(input logic [IW-1:0] x);
    return (x == IW'(NUM_REQ - 1)) ? '0 : x + 1'b1;
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_addr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    assign rsp_rdata[g*DATA_WIDTH +: DATA_WIDTH] =
      (r_tag[g] == PORT_B) ? dout_b : dout_a;
  end

  dpram_arb_rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick_a (
    .i_mask  (req_valid),
    .i_start (r_ptr),
    .o_found (w_a_found),
    .o_idx   (w_a_idx)
  );

  // B may only share a cycle with A when both are reads or the
  // addresses differ.
  always_comb begin
    w_b_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_b_mask[i] = req_valid[i]
        && (IW'(i) != w_a_idx)
        && !((w_addr[i] == w_addr[w_a_idx])
             && (req_we[i] || req_we[w_a_idx]));
    end
  end

  assign w_b_start = f_next(w_a_idx);

  dpram_arb_rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick_b (
    .i_mask  (w_b_mask),
    .i_start (w_b_start),
    .o_found (w_b_found),
    .o_idx   (w_b_idx)
  );

  assign w_a_gnt = w_a_found && !rst;
  assign w_b_gnt = w_b_found && w_a_gnt;

  always_comb begin
    req_ready = '0;
    if (w_a_gnt) req_ready[w_a_idx] = 1'b1;
    if (w_b_gnt) req_ready[w_b_idx] = 1'b1;
  end

  assign we_a   = w_a_gnt && req_we[w_a_idx];
  assign addr_a = w_a_gnt ? w_addr[w_a_idx]  : '0;
  assign din_a  = w_a_gnt ? w_wdata[w_a_idx] : '0;
  assign we_b   = w_b_gnt && req_we[w_b_idx];
  assign addr_b = w_b_gnt ? w_addr[w_b_idx]  : '0;
  assign din_b  = w_b_gnt ? w_wdata[w_b_idx] : '0;

  assign rsp_valid = r_rsp_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_rsp_valid <= '0;
      for (int i = 0; i < NUM_REQ; i++) r_tag[i] <= PORT_A;
    end else begin
      r_rsp_valid <= req_ready;
      for (int i = 0; i < NUM_REQ; i++) begin
        r_tag[i] <= (w_b_gnt && (w_b_idx == IW'(i))) ? PORT_B : PORT_A;
      end
      if (w_b_gnt)      r_ptr <= f_next(w_b_idx);
      else if (w_a_gnt) r_ptr <= f_next(w_a_idx);
    end
  end

endmodule

// File: tb/tb_dpram_arbiter.sv
// Scoreboard bench for dpram_arbiter with a behavioural read-first RAM.
module tb_dpram_arbiter;

  localparam int AW = 6;
  localparam int DW = 8;
  localparam int N  = 4;

  typedef struct {
    int          id;
    logic [DW-1:0] d;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [N*DW-1:0] rsp_rdata;
  logic            we_a, we_b;
  logic [AW-1:0]   addr_a, addr_b;
  logic [DW-1:0]   din_a, din_b;
  logic [DW-1:0]   dout_a, dout_b;

  logic [DW-1:0] ram     [1<<AW];
  logic [DW-1:0] ref_mem [1<<AW];
  exp_t          sb_q    [$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            rsp_cnt  [N];

  always #5 clk = ~clk;

  dpram_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REQ    (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .we_a      (we_a),
    .addr_a    (addr_a),
    .din_a     (din_a),
    .we_b      (we_b),
    .addr_b    (addr_b),
    .din_b     (din_b),
    .dout_a    (dout_a),
    .dout_b    (dout_b)
  );

  always @(posedge clk) begin
    if (we_a) ram[addr_a] <= din_a;
    if (we_b) ram[addr_b] <= din_b;
    dout_a <= ram[addr_a];
    dout_b <= ram[addr_b];
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_req();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic set_req(input int i, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]         = 1'b1;
    req_we[i]            = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic go(input logic [N-1:0] exp_rdy, input bit chk_rdy);
    logic [N-1:0]  acc;
    logic [AW-1:0] ai, aj;
    exp_t          e;
    #1;
    if (chk_rdy) check("ready", req_ready, exp_rdy);
    check("rdy_max2", ($countones(req_ready) <= 2), 1);
    check("rdy_no_valid", req_ready & ~req_valid, 0);
    for (int i = 0; i < N; i++)
      for (int j = i + 1; j < N; j++)
        if (req_ready[i] && req_ready[j]) begin
          ai = req_addr[i*AW +: AW];
          aj = req_addr[j*AW +: AW];
          check("conflict", (ai == aj) && (req_we[i] || req_we[j]), 0);
        end
    acc = req_valid & req_ready;
    for (int i = 0; i < N; i++)
      if (acc[i]) begin
        e.id = i;
        e.d  = ref_mem[req_addr[i*AW +: AW]];
        sb_q.push_back(e);
      end
    for (int i = 0; i < N; i++)
      if (acc[i] && req_we[i])
        ref_mem[req_addr[i*AW +: AW]] = req_wdata[i*DW +: DW];
    @(posedge clk);
    #1;
    check("rsp_valid", rsp_valid, acc);
    for (int i = 0; i < N; i++)
      if (rsp_valid[i]) begin
        rsp_cnt[i]++;
        if (sb_q.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("rsp_id", i, e.id);
          check("rsp_data", rsp_rdata[i*DW +: DW], e.d);
        end
      end
    clear_req();
  endtask

  initial begin
    for (int k = 0; k < (1 << AW); k++) begin
      ram[k]     = '0;
      ref_mem[k] = '0;
    end
    for (int i = 0; i < N; i++) rsp_cnt[i] = 0;
    clear_req();
    rst = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i), 8'h11);
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_we_a", we_a, 0);
    check("rst_we_b", we_b, 0);
    check("rst_rsp", rsp_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_req();

    // Idle: ports parked at zero, pointer stays at 0.
    #1;
    check("idle_we_a", we_a, 0);
    check("idle_we_b", we_b, 0);
    check("idle_addr_a", addr_a, 0);
    check("idle_addr_b", addr_b, 0);
    go(4'b0000, 1);

    // Write then read back through a different requester.
    set_req(0, 1'b1, 6'd5, 8'hA5);
    #1;
    check("wr_we_a", we_a, 1);
    check("wr_addr_a", addr_a, 5);
    check("wr_din_a", din_a, 8'hA5);
    go(4'b0001, 1);
    set_req(1, 1'b0, 6'd5, 8'h00);
    go(4'b0010, 1);
    go(4'b0000, 1);

    // Same-address reads share the cycle; ptr=2 here.
    set_req(2, 1'b0, 6'd3, 8'h00);
    set_req(3, 1'b0, 6'd3, 8'h00);
    #1;
    check("rr_addr_a", addr_a, 3);
    check("rr_addr_b", addr_b, 3);
    go(4'b1100, 1);

    // Write/read conflict at ptr=0: reader waits a cycle.
    set_req(0, 1'b1, 6'd9, 8'h5C);
    set_req(1, 1'b0, 6'd9, 8'h00);
    go(4'b0001, 1);
    set_req(1, 1'b0, 6'd9, 8'h00);
    go(4'b0010, 1);
    go(4'b0000, 1);

    // Reset with a read in flight (ptr=2, req1 only).
    set_req(1, 1'b0, 6'd20, 8'h00);
    #1;
    check("pre_rst_ready", req_ready, 4'b0010);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_drop_rsp", rsp_valid, 0);
    check("rst_mid_ready", req_ready, 0);
    check("rst_mid_we_a", we_a, 0);
    clear_req();
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_rsp", rsp_valid, 0);

    // Saturated load: pairs {0,1},{2,3} from ptr=0.
    for (int i = 0; i < N; i++) rsp_cnt[i] = 0;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++)
        set_req(i, (i % 2) == 0, AW'(16 + 4*c + i), DW'(16*c + i));
      go((c % 2) == 0 ? 4'b0011 : 4'b1100, 1);
    end
    go(4'b0000, 1);
    for (int i = 0; i < N; i++) check("sat_count", rsp_cnt[i], 4);

    // Random traffic over a tiny address range to stress conflicts.
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 3) != 0)
          set_req(i, $urandom_range(0, 1) == 1,
                  AW'($urandom_range(0, 3)), DW'($urandom_range(0, 255)));
      go('0, 0);
    end
    go(4'b0000, 1);
    check("sb_left", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
